// File: rtl/exception_vector_fetch_if.sv
// Signal bundle between the exception vector fetch sequencer and its environment
// (exception sources, PC/EPC registers and the memory read path).
interface exception_vector_fetch_if;
    // Requests are levels, looked at only while the sequencer is idle; pc_write and
    // epc_write are single-cycle strobes; src_addr_sel is held steady until the handler byte is taken.
    logic        exc_opcode;
    logic        exc_overflow;
    logic        exc_divzero;
    logic [31:0] pc_current;
    logic [31:0] mem_data_in;
    logic [2:0]  src_addr_sel;
    logic        busy;
    logic [1:0]  exc_cause;
    logic [31:0] epc_out;
    logic        epc_write;
    logic [31:0] pc_out;
    logic        pc_write;
    logic [1:0]  dbg_state;

    modport master (
        output exc_opcode, exc_overflow, exc_divzero, pc_current, mem_data_in,
        input  src_addr_sel, busy, exc_cause, epc_out, epc_write, pc_out, pc_write, dbg_state
    );

    modport slave (
        input  exc_opcode, exc_overflow, exc_divzero, pc_current, mem_data_in,
        output src_addr_sel, busy, exc_cause, epc_out, epc_write, pc_out, pc_write, dbg_state
    );
endinterface

// File: rtl/exception_vector_fetch.sv
// Services processor exceptions by reading the handler byte from vector 253/254/255,
// then loading PC with the handler and EPC with the faulting instruction address.
module exception_vector_fetch #(
    parameter int MEM_WAIT = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    exception_vector_fetch_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_CAPTURE = 2'd2,
        S_COMMIT  = 2'd3
    } state_t;

    localparam logic [3:0] LP_WAIT = 4'(MEM_WAIT);

    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_cause;
    logic [31:0] r_epc;
    logic [31:0] r_epc_out;
    logic [31:0] r_handler;
    logic [3:0]  r_cnt;
    logic        w_accept;
    logic [1:0]  w_cause_sel;

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_cause_sel  = 2'd0;
        if (bus.exc_opcode) begin
            w_cause_sel = 2'd1;
        end else if (bus.exc_overflow) begin
            w_cause_sel = 2'd2;
        end else if (bus.exc_divzero) begin
            w_cause_sel = 2'd3;
        end
        case (r_state)
            S_IDLE: begin
                if (bus.exc_opcode || bus.exc_overflow || bus.exc_divzero) begin
                    w_accept     = 1'b1;
                    w_state_next = S_WAIT;
                end
            end
            // Counter was loaded with MEM_WAIT on entry, so leaving at 1 gives MEM_WAIT cycles here.
            S_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_state_next = S_CAPTURE;
                end
            end
            S_CAPTURE: w_state_next = S_COMMIT;
            S_COMMIT:  w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cause   <= 2'd0;
            r_epc     <= 32'd0;
            r_epc_out <= 32'd0;
            r_handler <= 32'd0;
            r_cnt     <= 4'd0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cause <= w_cause_sel;
                        r_epc   <= bus.pc_current - 32'd4;
                        r_cnt   <= LP_WAIT;
                    end
                end
                S_WAIT: r_cnt <= r_cnt - 4'd1;
                // pc_out/epc_out change only here so they show the new values from COMMIT onwards.
                S_CAPTURE: begin
                    r_handler <= {24'd0, bus.mem_data_in[7:0]};
                    r_epc_out <= r_epc;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.src_addr_sel = 3'd0;
        bus.busy         = (r_state != S_IDLE);
        bus.pc_write     = 1'b0;
        bus.epc_write    = 1'b0;
        if (r_state == S_WAIT || r_state == S_CAPTURE) begin
            bus.src_addr_sel = {1'b0, r_cause};
        end
        if (r_state == S_COMMIT) begin
            bus.pc_write  = 1'b1;
            bus.epc_write = 1'b1;
        end
    end

    assign bus.exc_cause = r_cause;
    assign bus.epc_out   = r_epc_out;
    assign bus.pc_out    = r_handler;
    assign bus.dbg_state = r_state;
endmodule
